stream_demux: RTL and testbench
===============================

# stream_demux

Registered 1-to-N stream demultiplexer: steers a single valid/ready byte stream to one of N_OUT output channels, each of which has its own one-entry output register. It is the fan-out counterpart of the team's registered 2:1 selector and sits between a shared producer and per-channel consumers. The channel is latched on the first beat of a packet and held until the last beat, so packets are never split across channels.

## Interface
- WIDTH, 8, data width in bits
- N_OUT, 2, number of output channels (2..8)
- SEL_W, $clog2(N_OUT) (min 1), select width; derived, not overridden
---
- clk_i  input  1  clock; all logic on rising edge
- reset_n  input  1  synchronous, active-low reset, sampled on clk_i
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  WIDTH  input beat payload
- in_last  input  1  marks final beat of a packet
- sel  input  SEL_W  destination channel; sampled only on first beat of a packet
- out_valid  output  N_OUT  per-channel beat valid
- out_ready  input  N_OUT  per-channel consumer ready
- out_data  output  N_OUT*WIDTH  channel k payload at bits [k*WIDTH +: WIDTH]
- out_last  output  N_OUT  per-channel last flag
- err_sel  output  1  one-cycle pulse: first beat of a packet carried sel >= N_OUT

## Operation
- Reset (reset_n=0 at a rising edge): out_valid=0, out_data=0, out_last=0, err_sel=0, state=IDLE, lock_ch=0. in_ready is combinational and reads 0 while any state is under reset. Reset mid-packet discards buffered beats and the lock.
- FSM states: IDLE (no packet open), LOCKED (packet open on lock_ch), DROP (packet open with invalid sel).
- Active channel: in IDLE it is sel; in LOCKED it is lock_ch. sel is ignored in LOCKED and DROP.
- in_ready depends on the state. In IDLE with valid sel, and in LOCKED, in_ready = !out_valid[ch] || out_ready[ch] for the active ch. In IDLE with invalid sel, and in DROP, in_ready = 1.
- An accepted beat to channel ch loads out_data[ch]=in_data and out_last[ch]=in_last, and sets out_valid[ch]=1 on the next edge.
- Each channel slot clears out_valid when out_ready[ch] is high and no new beat loads it in that cycle. A simultaneous drain and load keeps out_valid=1 with the new data, giving full throughput.
- Channels are independent. Non-active channels keep draining while the input is stalled.
- In IDLE, an accepted beat with valid sel and in_last=0 moves to LOCKED with lock_ch=sel. With in_last=1 (a single-beat packet), the state stays IDLE.
- In IDLE, an accepted beat with sel >= N_OUT is dropped. err_sel pulses on the next cycle. If in_last=0 the state moves to DROP.
- In LOCKED or DROP, an accepted beat with in_last=1 returns the state to IDLE. A new sel takes effect on the very next beat.
- Data is never modified. out_data and out_last hold their value while out_valid=1 && out_ready=0.

## Timing
- Latency is 1 cycle: a beat accepted at edge t appears on out_* after edge t.
- Throughput is 1 beat/cycle per channel when the consumer holds ready.
- in_ready has a combinational path from out_ready and sel. There is no combinational path from in_valid to in_ready.
- err_sel is registered: high for exactly one cycle after the offending acceptance.
- Back-to-back packets to different channels need no idle cycle.

## Structure
- Package stream_demux_pkg holds:
  - the state enum typedef (IDLE, LOCKED, DROP);
  - a helper function for the SEL_W calculation.
- Sub-module stream_demux_slot is a one-entry register stage:
  - ports: clk_i, reset_n, load, din, last_in, ready, valid, dout, last_out;
  - instantiated N_OUT times via generate.
- The top level contains only the FSM, the lock register, the ready mux and err_sel.

## Test plan
- Reset then idle: after reset, all outputs are 0. With out_ready=2'b00, in_valid=1, sel=1, in_data=8'hA5 and in_last=1, the beat is accepted. Next cycle out_valid=2'b10, channel 1 data=8'hA5; in_ready for sel=1 is now 0.
- Locking: send a 3-beat packet 8'h11, 22, 33 with sel=0 on beat 1 and sel=1 on beats 2-3. All three beats appear on channel 0 only, and the state returns to IDLE after 8'h33.
- Backpressure: hold out_ready[0]=0 for 4 cycles during a channel-0 packet. in_ready stays 0, out_data[0] is stable, and no beats are lost or duplicated after ready returns.
- Simultaneous drain/load: with out_ready[0]=1 continuously, stream 8 beats. out_valid[0] stays 1 for 8 consecutive cycles with the correct order.
- Invalid sel (N_OUT=3, sel=3): the 2-beat packet is accepted and dropped. err_sel pulses once, and no out_valid rises.
- Reset mid-packet: assert reset_n=0 after beat 2 of a 4-beat packet. All out_valid clear, the state is IDLE, and the next packet routes by its own sel.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared types and helpers for the stream demultiplexer
// Contents:
//   state_e   : packet FSM states (IDLE, LOCKED, DROP)
//   sel_width : select width for a given channel count (never below 1)
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        DROP   = 2'd2
    } state_e;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// rtl/stream_demux_slot.sv - one-entry output register stage for a single channel
// Ports:
//   clk_i, reset_n      : clock, synchronous active-low reset
//   load, din, last_in  : load strobe with the beat payload and last flag
//   ready               : downstream consumer ready
//   valid, dout, last_out : registered beat presented to the consumer
module stream_demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             last_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             last_out
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    // A load in the same cycle as a drain wins, so the slot stays full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = din;
            last_d  = last_in;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid    = valid_q;
    assign dout     = data_q;
    assign last_out = last_q;

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered 1-to-N stream demultiplexer with per-packet channel lock
// Ports:
//   clk_i, reset_n                         : clock, synchronous active-low reset
//   in_valid, in_ready, in_data, in_last   : shared producer stream
//   sel                                    : destination, sampled on the first beat of a packet
//   out_valid, out_ready, out_data, out_last : per-channel streams, channel k at [k*WIDTH +: WIDTH]
//   err_sel                                : one-cycle pulse after a first beat with sel >= N_OUT
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  N_OUT = 2,
    localparam int SEL_W = sel_width(N_OUT)
) (
    input  logic                   clk_i,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    input  logic [SEL_W-1:0]       sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_last,
    output logic                   err_sel
);

    // Padded to a power of two so any sel value indexes a defined bit.
    localparam int          NPAD    = 1 << SEL_W;
    localparam logic [31:0] N_OUT_U = N_OUT;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic             err_sel_q, err_sel_d;

    logic [NPAD-1:0]  free_pad;
    logic [SEL_W-1:0] ch;
    logic             sel_bad;
    logic             route;
    logic             accept;
    logic [N_OUT-1:0] load;

    // Ready mux and per-channel load strobes.
    always_comb begin
        free_pad              = '0;
        free_pad[N_OUT-1:0]   = ~out_valid | out_ready;
        sel_bad               = {{(32-SEL_W){1'b0}}, sel} >= N_OUT_U;
        ch                    = (state_q == LOCKED) ? lock_ch_q : sel;
        route                 = (state_q == LOCKED) || ((state_q == IDLE) && !sel_bad);

        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = sel_bad ? 1'b1 : free_pad[sel];
            LOCKED:  in_ready = free_pad[lock_ch_q];
            DROP:    in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
        if (!reset_n) begin
            in_ready = 1'b0;
        end

        accept = in_valid && in_ready;

        load = '0;
        for (int k = 0; k < N_OUT; k++) begin
            load[k] = accept && route && (ch == SEL_W'(k));
        end
    end

    // Packet FSM: opens a packet on its first beat, closes it on the last.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        err_sel_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_bad) begin
                        err_sel_d = 1'b1;
                        if (!in_last) begin
                            state_d = DROP;
                        end
                    end else if (!in_last) begin
                        state_d   = LOCKED;
                        lock_ch_d = sel;
                    end
                end
            end
            LOCKED, DROP: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
            err_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            err_sel_q <= err_sel_d;
        end
    end

    assign err_sel = err_sel_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        stream_demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk_i    (clk_i),
            .reset_n  (reset_n),
            .load     (load[k]),
            .din      (in_data),
            .last_in  (in_last),
            .ready    (out_ready[k]),
            .valid    (out_valid[k]),
            .dout     (out_data[k*WIDTH +: WIDTH]),
            .last_out (out_last[k])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - directed scoreboard bench for stream_demux with three channels
module tb_stream_demux;
    import stream_demux_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic [1:0]  sel;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [23:0] out_data;
    logic [2:0]  out_last;
    logic        err_sel;

    stream_demux #(
        .WIDTH (8),
        .N_OUT (3)
    ) dut (
        .clk_i     (clk_i),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err_sel   (err_sel)
    );

    always #5 clk_i = ~clk_i;

    int         vectors = 0;
    int         miscompares = 0;
    logic [8:0] exp_q [3][$];
    int         m_state;
    logic [1:0] m_ch;
    logic       err_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) exp_q[k].delete();
        m_state  = 0;
        m_ch     = 2'd0;
        err_pend = 1'b0;
    endtask

    // One clock: sample and score outputs on the falling edge, update the
    // reference model on an accepted beat, return #1 after the rising edge.
    task automatic tick(output logic acc);
        logic [31:0] exp_beat;
        @(negedge clk_i);
        acc = 1'b0;
        if (reset_n) begin
            chk("err_sel", {31'd0, err_sel}, {31'd0, err_pend});
            err_pend = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    exp_beat = (exp_q[k].size() > 0) ? {23'd0, exp_q[k].pop_front()} : 32'hDEAD;
                    chk($sformatf("ch%0d_beat", k), {23'd0, out_last[k], out_data[k*8 +: 8]}, exp_beat);
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin
                case (m_state)
                    0: begin
                        if (sel == 2'd3) begin
                            err_pend = 1'b1;
                            if (!in_last) m_state = 2;
                        end else begin
                            exp_q[sel].push_back({in_last, in_data});
                            if (!in_last) begin
                                m_state = 1;
                                m_ch    = sel;
                            end
                        end
                    end
                    1: begin
                        exp_q[m_ch].push_back({in_last, in_data});
                        if (in_last) m_state = 0;
                    end
                    default: if (in_last) m_state = 0;
                endcase
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l, input logic [1:0] s, output int n);
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        sel      = s;
        n        = 0;
        do begin
            tick(acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        out_ready = 3'b111;
        for (int i = 0; i < 6; i++) tick(acc);
        chk("drain_q0", exp_q[0].size(), 0);
        chk("drain_q1", exp_q[1].size(), 0);
        chk("drain_q2", exp_q[2].size(), 0);
        chk("drain_valid", {29'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic acc;
        int   n;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        sel       = 2'd1;
        out_ready = 3'b000;
        model_reset();
        tick(acc);
        tick(acc);
        chk("rst_valid", {29'd0, out_valid}, 32'd0);
        chk("rst_data", {8'd0, out_data}, 32'd0);
        chk("rst_last", {29'd0, out_last}, 32'd0);
        chk("rst_err", {31'd0, err_sel}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("idle_ready", {31'd0, in_ready}, 32'd1);

        // Single-beat packet to channel 1 with no consumer ready.
        send_beat(8'hA5, 1'b1, 2'd1, n);
        chk("t1_valid", {29'd0, out_valid}, 32'h2);
        chk("t1_data", {24'd0, out_data[15:8]}, 32'hA5);
        chk("t1_ready_ch1", {31'd0, in_ready}, 32'd0);
        sel = 2'd0;
        #1;
        chk("t1_ready_ch0", {31'd0, in_ready}, 32'd1);
        chk("t1_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        drain();

        // Lock: sel changes mid-packet must be ignored.
        out_ready = 3'b111;
        send_beat(8'h11, 1'b0, 2'd0, n);
        send_beat(8'h22, 1'b0, 2'd1, n);
        chk("lock_state", {30'd0, dut.state_q}, {30'd0, LOCKED});
        send_beat(8'h33, 1'b1, 2'd1, n);
        chk("lock_idle", {30'd0, dut.state_q}, {30'd0, IDLE});
        drain();

        // Backpressure on channel 0 for four cycles.
        out_ready = 3'b110;
        send_beat(8'h41, 1'b0, 2'd0, n);
        in_valid = 1'b1;
        in_data  = 8'h42;
        in_last  = 1'b0;
        sel      = 2'd2;
        for (int i = 0; i < 4; i++) begin
            tick(acc);
            chk("bp_accept", {31'd0, acc}, 32'd0);
            chk("bp_hold", {24'd0, out_data[7:0]}, 32'h41);
            chk("bp_valid", {31'd0, out_valid[0]}, 32'd1);
        end
        out_ready = 3'b111;
        send_beat(8'h42, 1'b0, 2'd2, n);
        send_beat(8'h43, 1'b1, 2'd2, n);
        drain();

        // Full throughput on channel 2.
        out_ready = 3'b111;
        for (int i = 0; i < 8; i++) begin
            send_beat(8'h80 + 8'(i), (i == 7), 2'd2, n);
            chk("tput_cycles", n, 1);
            chk("tput_valid", {31'd0, out_valid[2]}, 32'd1);
        end
        drain();

        // Invalid select: packet dropped, one err_sel pulse.
        out_ready = 3'b000;
        sel       = 2'd3;
        #1;
        chk("bad_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 3'b111;
        send_beat(8'hEE, 1'b0, 2'd3, n);
        chk("bad_state", {30'd0, dut.state_q}, {30'd0, DROP});
        chk("bad_valid1", {29'd0, out_valid}, 32'd0);
        send_beat(8'hEF, 1'b1, 2'd0, n);
        chk("bad_valid2", {29'd0, out_valid}, 32'd0);
        drain();

        // Reset in the middle of a packet on channel 1.
        out_ready = 3'b111;
        send_beat(8'h51, 1'b0, 2'd1, n);
        send_beat(8'h52, 1'b0, 2'd1, n);
        out_ready = 3'b000;
        chk("mid_valid", {29'd0, out_valid}, 32'h2);
        reset_n = 1'b0;
        model_reset();
        tick(acc);
        chk("mid_rst_valid", {29'd0, out_valid}, 32'd0);
        chk("mid_rst_state", {30'd0, dut.state_q}, {30'd0, IDLE});
        reset_n   = 1'b1;
        out_ready = 3'b111;
        send_beat(8'h77, 1'b1, 2'd0, n);
        chk("mid_new_valid", {29'd0, out_valid}, 32'h1);
        chk("mid_new_data", {24'd0, out_data[7:0]}, 32'h77);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
